// File: rtl/stream_route_ctrl_pkg.sv
// stream_route_ctrl_pkg: shared mode and FSM state encodings for the stream router
package stream_route_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_DEST = 2'b00,
        MODE_RR   = 2'b01,
        MODE_P0   = 2'b10,
        MODE_P1   = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/stream_route_ctrl_slice.sv
// route_out_slice: one-entry downstream output register with saturating delivered-beat counter
module route_out_slice #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic [CNT_W-1:0]  cnt,
    output logic              can_load
);

    assign can_load = !valid || ready;

    // load wins over drain so a back-to-back beat keeps valid high; data holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
            cnt   <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= in_data;
                last  <= in_last;
            end else if (ready) begin
                valid <= 1'b0;
            end
            if (valid && ready && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stream_route_ctrl.sv
// stream_route_ctrl: packet-locked 1-to-2 stream router with per-port output registers
module stream_route_ctrl
    import stream_route_ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_dest,
    input  logic              s_last,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_last,
    output logic [CNT_W-1:0]  m0_cnt,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_last,
    output logic [CNT_W-1:0]  m1_cnt,
    output logic              busy
);

    state_t state, state_nx;
    logic   lock_port, lock_nx, rr, rr_nx, run, sel, acc, can0, can1;

    // an open packet ignores mode and s_dest; otherwise mode picks the port
    assign sel = (state == PKT) ? lock_port :
                 (mode == MODE_DEST) ? s_dest :
                 (mode == MODE_RR) ? rr :
                 (mode == MODE_P1);

    // run keeps s_ready low during reset and until the first edge after release
    assign s_ready = run && (sel ? can1 : can0);
    assign acc     = s_valid && s_ready;
    assign busy    = (state == PKT);

    // FSM state, locked port, round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lock_port <= 1'b0;
            rr        <= 1'b0;
            run       <= 1'b0;
        end else begin
            state     <= state_nx;
            lock_port <= lock_nx;
            rr        <= rr_nx;
            run       <= 1'b1;
        end
    end

    // next state: any accepted beat opens/keeps a packet unless it is the last one
    always_comb begin
        state_nx = acc ? (s_last ? IDLE : PKT) : state;
        lock_nx  = acc ? sel : lock_port;
        rr_nx    = rr ^ (acc && s_last && mode == MODE_RR);
    end

    route_out_slice #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_p0 (
        .clk(clk), .rst_n(rst_n), .load(acc && !sel), .in_data(s_data), .in_last(s_last),
        .ready(m0_ready), .valid(m0_valid), .data(m0_data), .last(m0_last), .cnt(m0_cnt),
        .can_load(can0)
    );

    route_out_slice #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_p1 (
        .clk(clk), .rst_n(rst_n), .load(acc && sel), .in_data(s_data), .in_last(s_last),
        .ready(m1_ready), .valid(m1_valid), .data(m1_data), .last(m1_last), .cnt(m1_cnt),
        .can_load(can1)
    );

endmodule
